reg_file_idu: RTL and testbench
===============================

Name: reg_file_idu

Overview:
- Datapath stage directly downstream of the instruction decoder/sequencer.
- Holds the CPU register file: B, C, D, E, H, L, A, F, W, Z, SPH, SPL, PCH, PCL.
- Each cycle it drives the address bus, forms the internal data bus, presents ALU operands and runs the 16-bit increment/decrement unit (IDU).
- Commits 8-bit, 16-bit, PC and flag writebacks exactly as commanded by the decoder's per-step control word, and stalls on a slow memory.

Parameters:
RESET_PC, 16'h0000, PC value after reset.
RESET_SP, 16'hFFFE, SP value after reset.
DB_IDLE, 8'hFF, data bus value when s_db is NONE.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  synchronous reset, active-high.
s_ab  in  3  reg16_t address-bus source: WZ, BC, DE, HL, AF, SP, PC, PCH_ZERO.
s_db  in  4  reg8_t data-bus source (register, MEM or NONE).
t_db  in  4  reg8_t 8-bit writeback target (register, F, MEM or NONE).
s_r_wb  in  2  8-bit writeback value: DB, ALU or SRU.
s_acc  in  3  ALU accumulator source: A, DB, SPL, SPH or PCL.
s_arg  in  1  ALU argument source: DB or constant 1.
idu  in  2  IDU mode: INC, DEC or ADJ.
s_rr_wb  in  2  16-bit writeback source: NONE, IDU or WZ.
t_rr_wb  in  3  reg16_t 16-bit writeback target.
wr_pc  in  1  load PC from IDU output.
fetch  in  1  opcode fetch this cycle (decoder done).
alu_result  in  8  ALU result.
alu_carry  in  1  ALU carry out (used only by ADJ).
sru_result  in  8  shift/rotate unit result.
flags_we  in  1  write ALU flags into F.
flags_in  in  4  {z,n,h,c} from ALU.
mem_rdata  in  8  memory read data.
mem_ready  in  1  memory completes access this cycle.
mem_addr  out  16  address bus.
mem_rd  out  1  memory read strobe.
mem_we  out  1  memory write strobe.
mem_wdata  out  8  memory write data.
stall  out  1  hold sequencer; no state committed this cycle.
alu_acc  out  8  ALU accumulator operand.
alu_arg  out  8  ALU argument operand.
flags_out  out  4  F[7:4] as {z,n,h,c} for condition evaluation.
pc_out  out  16  current PC.

Behaviour:
- Reset (rst=1 at a clock edge):
  - PC=RESET_PC, SP=RESET_SP; all other registers 0.
  - Combinational outputs follow the reset state.
- F low nibble:
  - Always reads 0; writes to F[3:0] are discarded.
- Address mux (combinational):
  - mem_addr = selected 16-bit pair.
  - PCH_ZERO gives {PCH, 8'h00}.
  - AF gives {A, F & 8'hF0}.
- Data bus (combinational):
  - MEM selects mem_rdata; NONE selects DB_IDLE; a register selects its value.
- ALU operands:
  - alu_acc is muxed per s_acc.
  - alu_arg = db when s_arg is DB, 8'h01 when s_arg is ONE.
- IDU:
  - INC gives mem_addr+1; DEC gives mem_addr-1; both wrap modulo 2^16.
  - ADJ gives mem_addr + (adj<<8), where adj is taken from the current Z value (before any update this cycle):
    - adj = +1 when alu_carry=1 and Z[7]=0.
    - adj = -1 when alu_carry=0 and Z[7]=1.
    - adj = 0 otherwise.
- Writeback value:
  - wb8 = db, alu_result or sru_result per s_r_wb.
- Memory strobes:
  - mem_rd = (s_db==MEM) | fetch.
  - mem_we = (t_db==MEM); mem_wdata = wb8.
  - s_db==MEM together with t_db==MEM is illegal; assert in simulation.
- Stall:
  - stall = (mem_rd|mem_we) & !mem_ready.
  - While stall=1, no register, PC or F update is committed and all outputs hold their combinational values.
  - The same control word is re-presented by the sequencer until mem_ready=1.
- Commit order, applied when not stalled; later items override earlier ones on the same byte:
  1. flags_we writes F[7:4] = flags_in.
  2. The 16-bit writeback to t_rr_wb, high byte then low byte:
     - IDU source writes idu_out; WZ source writes {W,Z}.
     - t_rr_wb is ignored when s_rr_wb is NONE.
  3. wr_pc writes PC = idu_out.
  4. The 8-bit writeback: t_db register = wb8; F target writes wb8[7:4].
- Simultaneous-event rules follow from the commit order:
  - An 8-bit write to Z wins over a WZ 16-bit write, so during ADJ only W takes the IDU value.
  - A t_db==F write wins over flags_we.
- Reset mid-access:
  - rst wins over stall; strobes still follow the combinational rules.
- Latency:
  - Reads are combinational in the same cycle.
  - Writes become visible the cycle after commit.

Test Plan:
1. Reset with rst=1, then release -> pc_out=0000, SP=FFFE, flags_out=0, mem_addr=0000 with s_ab=PC.
2. s_ab=PC, idu=INC, wr_pc=1, fetch=1, mem_ready=0 for 2 cycles then 1 -> stall=1 for 2 cycles, PC unchanged, then PC=0001.
3. SP=0000, s_ab=SP, idu=DEC, s_rr_wb=IDU, t_rr_wb=SP -> SP=FFFF (wrap).
4. JR step with PC=12F0, Z=20, alu_result=10, alu_carry=1, t_db=Z, s_rr_wb=IDU, t_rr_wb=WZ, idu=ADJ, s_ab=PCH_ZERO -> W=13, Z=10. Repeat with Z=F0, alu_carry=0 -> W=11.
5. t_db=F, wb8=FF, flags_we=1, flags_in=0 -> F=F0, flags_out=F. Then POP-style WZ=1234 into AF -> A=12, F=30.
6. t_db=MEM, s_db=B with B=5A, s_ab=HL with HL=C000 -> mem_we=1, mem_addr=C000, mem_wdata=5A, mem_rd=0.

Source files
------------

// File: rtl/reg_file_idu.sv
// CPU register file with address/data bus muxing, ALU operand selection and the 16-bit IDU.
// Commits 8/16-bit, PC and flag writebacks from the decoder's control word and stalls on slow memory.
module reg_file_idu #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] RESET_SP = 16'hFFFE,
    parameter logic [7:0]  DB_IDLE  = 8'hFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  s_ab,
    input  logic [3:0]  s_db,
    input  logic [3:0]  t_db,
    input  logic [1:0]  s_r_wb,
    input  logic [2:0]  s_acc,
    input  logic        s_arg,
    input  logic [1:0]  idu,
    input  logic [1:0]  s_rr_wb,
    input  logic [2:0]  t_rr_wb,
    input  logic        wr_pc,
    input  logic        fetch,
    input  logic [7:0]  alu_result,
    input  logic        alu_carry,
    input  logic [7:0]  sru_result,
    input  logic        flags_we,
    input  logic [3:0]  flags_in,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ready,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    output logic        mem_we,
    output logic [7:0]  mem_wdata,
    output logic        stall,
    output logic [7:0]  alu_acc,
    output logic [7:0]  alu_arg,
    output logic [3:0]  flags_out,
    output logic [15:0] pc_out
);
    // reg8_t: 0..13 index the register file directly
    localparam logic [3:0] R_B = 4'd0, R_C = 4'd1, R_D = 4'd2, R_E = 4'd3, R_H = 4'd4, R_L = 4'd5,
                           R_A = 4'd6, R_F = 4'd7, R_W = 4'd8, R_Z = 4'd9, R_SPH = 4'd10,
                           R_SPL = 4'd11, R_PCH = 4'd12, R_PCL = 4'd13, R_MEM = 4'd14, R_NONE = 4'd15;
    // reg16_t
    localparam logic [2:0] P_WZ = 3'd0, P_BC = 3'd1, P_DE = 3'd2, P_HL = 3'd3, P_AF = 3'd4,
                           P_SP = 3'd5, P_PC = 3'd6, P_PCH_ZERO = 3'd7;
    localparam logic [1:0] WB_DB = 2'd0, WB_ALU = 2'd1, WB_SRU = 2'd2;
    localparam logic [2:0] ACC_A = 3'd0, ACC_DB = 3'd1, ACC_SPL = 3'd2, ACC_SPH = 3'd3, ACC_PCL = 3'd4;
    localparam logic [1:0] IDU_INC = 2'd0, IDU_DEC = 2'd1, IDU_ADJ = 2'd2;
    localparam logic [1:0] RR_NONE = 2'd0, RR_IDU = 2'd1, RR_WZ = 2'd2;

    logic [13:0][7:0] rf;
    logic [7:0]       db, wb8, adj;
    logic [15:0]      idu_out, rr_val;
    logic             rr_en;

    always_comb begin
        case (s_ab)
            P_WZ:       mem_addr = {rf[R_W], rf[R_Z]};
            P_BC:       mem_addr = {rf[R_B], rf[R_C]};
            P_DE:       mem_addr = {rf[R_D], rf[R_E]};
            P_HL:       mem_addr = {rf[R_H], rf[R_L]};
            P_AF:       mem_addr = {rf[R_A], rf[R_F] & 8'hF0};
            P_SP:       mem_addr = {rf[R_SPH], rf[R_SPL]};
            P_PC:       mem_addr = {rf[R_PCH], rf[R_PCL]};
            default:    mem_addr = {rf[R_PCH], 8'h00};
        endcase
    end

    always_comb begin
        db = DB_IDLE;
        if (s_db == R_MEM)      db = mem_rdata;
        else if (s_db == R_F)   db = rf[R_F] & 8'hF0;
        else if (s_db != R_NONE) db = rf[s_db];
    end

    always_comb begin
        case (s_acc)
            ACC_DB:  alu_acc = db;
            ACC_SPL: alu_acc = rf[R_SPL];
            ACC_SPH: alu_acc = rf[R_SPH];
            ACC_PCL: alu_acc = rf[R_PCL];
            default: alu_acc = rf[R_A];
        endcase
    end
    assign alu_arg = s_arg ? 8'h01 : db;

    // ADJ sign-corrects the high byte after a signed 8-bit offset was added to the low byte
    always_comb begin
        adj = 8'h00;
        if (alu_carry && !rf[R_Z][7])      adj = 8'h01;
        else if (!alu_carry && rf[R_Z][7]) adj = 8'hFF;
        case (idu)
            IDU_INC: idu_out = mem_addr + 16'h0001;
            IDU_DEC: idu_out = mem_addr - 16'h0001;
            IDU_ADJ: idu_out = mem_addr + {adj, 8'h00};
            default: idu_out = mem_addr;
        endcase
    end

    always_comb begin
        case (s_r_wb)
            WB_ALU:  wb8 = alu_result;
            WB_SRU:  wb8 = sru_result;
            default: wb8 = db;
        endcase
    end

    assign rr_en     = (s_rr_wb == RR_IDU) || (s_rr_wb == RR_WZ);
    assign rr_val    = (s_rr_wb == RR_IDU) ? idu_out : {rf[R_W], rf[R_Z]};
    assign mem_rd    = (s_db == R_MEM) | fetch;
    assign mem_we    = (t_db == R_MEM);
    assign mem_wdata = wb8;
    assign stall     = (mem_rd | mem_we) & ~mem_ready;
    assign flags_out = rf[R_F][7:4];
    assign pc_out    = {rf[R_PCH], rf[R_PCL]};

    // Later assignments override earlier ones on the same byte, giving the commit priority
    always_ff @(posedge clk) begin
        if (rst) begin
            rf        <= '0;
            rf[R_SPH] <= RESET_SP[15:8];
            rf[R_SPL] <= RESET_SP[7:0];
            rf[R_PCH] <= RESET_PC[15:8];
            rf[R_PCL] <= RESET_PC[7:0];
        end else if (!stall) begin
            if (flags_we) rf[R_F] <= {flags_in, 4'h0};
            if (rr_en) begin
                case (t_rr_wb)
                    P_WZ: begin rf[R_W] <= rr_val[15:8]; rf[R_Z] <= rr_val[7:0]; end
                    P_BC: begin rf[R_B] <= rr_val[15:8]; rf[R_C] <= rr_val[7:0]; end
                    P_DE: begin rf[R_D] <= rr_val[15:8]; rf[R_E] <= rr_val[7:0]; end
                    P_HL: begin rf[R_H] <= rr_val[15:8]; rf[R_L] <= rr_val[7:0]; end
                    P_AF: begin rf[R_A] <= rr_val[15:8]; rf[R_F] <= {rr_val[7:4], 4'h0}; end
                    P_SP: begin rf[R_SPH] <= rr_val[15:8]; rf[R_SPL] <= rr_val[7:0]; end
                    P_PC: begin rf[R_PCH] <= rr_val[15:8]; rf[R_PCL] <= rr_val[7:0]; end
                    default: ;
                endcase
            end
            if (wr_pc) begin
                rf[R_PCH] <= idu_out[15:8];
                rf[R_PCL] <= idu_out[7:0];
            end
            if (t_db == R_F)        rf[R_F] <= {wb8[7:4], 4'h0};
            else if (t_db <= R_PCL) rf[t_db] <= wb8;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) assert (!(s_db == R_MEM && t_db == R_MEM));
    end
endmodule

// File: tb/tb_reg_file_idu.sv
// Directed bench for reg_file_idu: reset, stall, IDU wrap/adjust, flags, memory write, operands.
module tb_reg_file_idu;
    logic        clk = 1'b0, rst = 1'b1;
    logic [2:0]  s_ab, s_acc, t_rr_wb;
    logic [3:0]  s_db, t_db, flags_in;
    logic [1:0]  s_r_wb, idu, s_rr_wb;
    logic        s_arg, wr_pc, fetch, alu_carry, flags_we, mem_ready;
    logic [7:0]  alu_result, sru_result, mem_rdata;
    logic [15:0] mem_addr, pc_out;
    logic        mem_rd, mem_we, stall;
    logic [7:0]  mem_wdata, alu_acc, alu_arg;
    logic [3:0]  flags_out;
    int checks = 0, failures = 0;

    localparam logic [3:0] B = 0, C = 1, H = 4, L = 5, F = 7, W = 8, Z = 9, SPH = 10, SPL = 11,
                           PCH = 12, PCL = 13, MEM = 14, NONE = 15;
    localparam logic [2:0] P_WZ = 0, P_HL = 3, P_AF = 4, P_SP = 5, P_PC = 6, P_PCHZ = 7;

    reg_file_idu dut (
        .clk(clk), .rst(rst), .s_ab(s_ab), .s_db(s_db), .t_db(t_db), .s_r_wb(s_r_wb),
        .s_acc(s_acc), .s_arg(s_arg), .idu(idu), .s_rr_wb(s_rr_wb), .t_rr_wb(t_rr_wb),
        .wr_pc(wr_pc), .fetch(fetch), .alu_result(alu_result), .alu_carry(alu_carry),
        .sru_result(sru_result), .flags_we(flags_we), .flags_in(flags_in),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_rd(mem_rd),
        .mem_we(mem_we), .mem_wdata(mem_wdata), .stall(stall), .alu_acc(alu_acc),
        .alu_arg(alu_arg), .flags_out(flags_out), .pc_out(pc_out));

    always #5 clk = ~clk;

    task automatic idle();
        s_ab = P_PC; s_db = NONE; t_db = NONE; s_r_wb = 0; s_acc = 0; s_arg = 0; idu = 0;
        s_rr_wb = 0; t_rr_wb = P_WZ; wr_pc = 0; fetch = 0; alu_result = 0; alu_carry = 0;
        sru_result = 0; flags_we = 0; flags_in = 0; mem_rdata = 0; mem_ready = 1;
    endtask

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic load8(input logic [3:0] r, input logic [7:0] v);
        idle(); s_db = MEM; t_db = r; mem_rdata = v; cyc(); idle();
    endtask

    task automatic test_reset();
        idle(); rst = 1; cyc(); cyc(); rst = 0; #1;
        checks++; if (pc_out !== 16'h0000) begin failures++; $display("FAIL reset_pc got=%h exp=0000", pc_out); end
        checks++; if (mem_addr !== 16'h0000) begin failures++; $display("FAIL reset_addr got=%h exp=0000", mem_addr); end
        checks++; if (flags_out !== 4'h0) begin failures++; $display("FAIL reset_flags got=%h exp=0", flags_out); end
        s_ab = P_SP; #1;
        checks++; if (mem_addr !== 16'hFFFE) begin failures++; $display("FAIL reset_sp got=%h exp=FFFE", mem_addr); end
        s_ab = P_HL; #1;
        checks++; if (mem_addr !== 16'h0000) begin failures++; $display("FAIL reset_hl got=%h exp=0000", mem_addr); end
    endtask

    task automatic test_stall();
        idle(); idu = 0; wr_pc = 1; fetch = 1; mem_ready = 0; #1;
        checks++; if (stall !== 1'b1 || mem_rd !== 1'b1) begin failures++; $display("FAIL stall_on got=%b%b exp=11", stall, mem_rd); end
        cyc(); cyc();
        checks++; if (pc_out !== 16'h0000 || stall !== 1'b1) begin failures++; $display("FAIL stall_hold got=%h exp=0000", pc_out); end
        mem_ready = 1; #1;
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL stall_release got=%b exp=0", stall); end
        cyc(); idle(); #1;
        checks++; if (pc_out !== 16'h0001) begin failures++; $display("FAIL stall_pc_inc got=%h exp=0001", pc_out); end
    endtask

    task automatic test_sp_wrap();
        load8(SPH, 8'h00); load8(SPL, 8'h00);
        s_ab = P_SP; idu = 1; s_rr_wb = 1; t_rr_wb = P_SP; cyc(); idle(); s_ab = P_SP; #1;
        checks++; if (mem_addr !== 16'hFFFF) begin failures++; $display("FAIL sp_dec_wrap got=%h exp=FFFF", mem_addr); end
        idu = 0; s_rr_wb = 1; t_rr_wb = P_SP; cyc(); idle(); s_ab = P_SP; #1;
        checks++; if (mem_addr !== 16'h0000) begin failures++; $display("FAIL sp_inc_wrap got=%h exp=0000", mem_addr); end
    endtask

    task automatic jr_step(input logic [7:0] z0, input logic cy);
        load8(PCH, 8'h12); load8(PCL, 8'hF0); load8(Z, z0);
        s_ab = P_PCHZ; idu = 2; alu_result = 8'h10; alu_carry = cy; s_r_wb = 1; t_db = Z;
        s_rr_wb = 1; t_rr_wb = P_WZ; cyc(); idle(); s_ab = P_WZ; #1;
    endtask

    task automatic test_jr();
        idle(); s_ab = P_PCHZ; load8(PCH, 8'h12); load8(PCL, 8'hF0); s_ab = P_PCHZ; #1;
        checks++; if (mem_addr !== 16'h1200) begin failures++; $display("FAIL pch_zero got=%h exp=1200", mem_addr); end
        jr_step(8'h20, 1'b1);
        checks++; if (mem_addr !== 16'h1310) begin failures++; $display("FAIL jr_fwd got=%h exp=1310", mem_addr); end
        jr_step(8'hF0, 1'b0);
        checks++; if (mem_addr !== 16'h1110) begin failures++; $display("FAIL jr_back got=%h exp=1110", mem_addr); end
        jr_step(8'h80, 1'b1);
        checks++; if (mem_addr !== 16'h1210) begin failures++; $display("FAIL jr_noadj got=%h exp=1210", mem_addr); end
    endtask

    task automatic test_flags();
        idle(); flags_we = 1; flags_in = 4'h5; cyc(); idle(); #1;
        checks++; if (flags_out !== 4'h5) begin failures++; $display("FAIL flags_we got=%h exp=5", flags_out); end
        s_db = MEM; mem_rdata = 8'hFF; t_db = F; flags_we = 1; flags_in = 4'h0; cyc(); idle(); s_ab = P_AF; #1;
        checks++; if (flags_out !== 4'hF) begin failures++; $display("FAIL flags_tdb_wins got=%h exp=F", flags_out); end
        checks++; if (mem_addr !== 16'h00F0) begin failures++; $display("FAIL f_low_nibble got=%h exp=00F0", mem_addr); end
        load8(W, 8'h12); load8(Z, 8'h34);
        s_rr_wb = 2; t_rr_wb = P_AF; cyc(); idle(); s_ab = P_AF; #1;
        checks++; if (mem_addr !== 16'h1230 || flags_out !== 4'h3) begin failures++; $display("FAIL pop_af got=%h/%h exp=1230/3", mem_addr, flags_out); end
    endtask

    task automatic test_mem_write();
        load8(B, 8'h5A); load8(H, 8'hC0); load8(L, 8'h00);
        s_db = B; t_db = MEM; s_ab = P_HL; #1;
        checks++; if (mem_we !== 1'b1 || mem_rd !== 1'b0 || stall !== 1'b0) begin failures++; $display("FAIL mem_strobes got=%b%b%b exp=100", mem_we, mem_rd, stall); end
        checks++; if (mem_addr !== 16'hC000 || mem_wdata !== 8'h5A) begin failures++; $display("FAIL mem_write got=%h/%h exp=C000/5A", mem_addr, mem_wdata); end
        mem_ready = 0; #1;
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL write_stall got=%b exp=1", stall); end
        idle();
    endtask

    task automatic test_operands();
        idle(); s_db = B; s_acc = 0; #1;
        checks++; if (alu_acc !== 8'h12 || alu_arg !== 8'h5A) begin failures++; $display("FAIL acc_a_arg_db got=%h/%h exp=12/5A", alu_acc, alu_arg); end
        s_acc = 1; s_arg = 1; #1;
        checks++; if (alu_acc !== 8'h5A || alu_arg !== 8'h01) begin failures++; $display("FAIL acc_db_arg_one got=%h/%h exp=5A/01", alu_acc, alu_arg); end
        s_acc = 4; s_arg = 0; s_db = NONE; #1;
        checks++; if (alu_acc !== 8'hF0 || alu_arg !== 8'hFF) begin failures++; $display("FAIL acc_pcl_idle got=%h/%h exp=F0/FF", alu_acc, alu_arg); end
        idle(); t_db = C; s_r_wb = 2; sru_result = 8'h3C; cyc(); idle(); s_db = C; #1;
        checks++; if (alu_arg !== 8'h3C) begin failures++; $display("FAIL sru_wb got=%h exp=3C", alu_arg); end
    endtask

    task automatic test_reset_mid();
        idle(); wr_pc = 1; fetch = 1; mem_ready = 0; rst = 1; #1;
        checks++; if (stall !== 1'b1 || mem_rd !== 1'b1) begin failures++; $display("FAIL rst_strobes got=%b%b exp=11", stall, mem_rd); end
        cyc(); rst = 0; idle(); #1;
        checks++; if (pc_out !== 16'h0000 || flags_out !== 4'h0) begin failures++; $display("FAIL rst_mid got=%h/%h exp=0000/0", pc_out, flags_out); end
        s_ab = P_SP; #1;
        checks++; if (mem_addr !== 16'hFFFE) begin failures++; $display("FAIL rst_mid_sp got=%h exp=FFFE", mem_addr); end
    endtask

    initial begin
        test_reset();
        test_stall();
        test_sp_wrap();
        test_jr();
        test_flags();
        test_mem_write();
        test_operands();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
